ocr_rx_packer: RTL and testbench

- Parametrised successor of the OCR receive unit.
- Accepts right-aligned, NULL-padded character segments from the OCR engine and filters them per character.
- Packs accepted characters into FILO words of configurable width and pushes them with ready/valid backpressure.
- On final image, flushes any partial word, reports total character count, and signals done to the bridge controller.

---
 rtl/ocr_rx_packer.sv | 251 +++++++++++++++++++++++++
 tb/tb_ocr_rx_packer.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ocr_rx_packer.sv
// ---------------------------------------------------------------------------
// ocr_rx_packer
//
// Receives right-aligned, NULL-padded character segments from the OCR engine,
// keeps only accepted characters (digits, plus uppercase letters when the
// OCR_RX_ALPHA_EN macro is defined), packs them into FILO words and pushes the
// words out. When the image ends, any partial word is flushed and done is
// raised until final_image drops.
//
// Configuration macro:
//   OCR_RX_ALPHA_EN  defined   -> 'A'-'Z' are accepted as well as '0'-'9'
//                    undefined -> only '0'-'9' are accepted
//
// Ports:
//   clk_in        clock
//   rst           synchronous active-high reset
//   char_output   input segment, char i at [CHAR_WIDTH*i +: CHAR_WIDTH]
//   valid_output  segment valid (single-cycle pulse)
//   seg_ready     high only in IDLE
//   final_image   end-of-image level
//   clear_buff    synchronous soft clear (same effect as rst)
//   data_to_filo  packed word
//   push_filo     word valid
//   filo_ready    FILO can accept
//   result_lc     accepted-character count, saturating at 255
//   ocr_rx_done   flush complete, held until final_image falls
//   overflow      sticky, a character was dropped at capacity
//   seg_dropped   one-cycle pulse, segment offered while seg_ready=0
//   dbg_state     current FSM state (IDLE=0 SCAN=1 PUSH=2 FLUSH=3 DONE=4)
//
// Handshakes: a segment is taken on a cycle where valid_output && seg_ready;
// a word is transferred on a cycle where push_filo && filo_ready, and
// push_filo/data_to_filo stay stable until that transfer happens.
// ---------------------------------------------------------------------------
module ocr_rx_packer #(
  parameter int MAX_OUT_L = 8,
  parameter int CHAR_WIDTH = 8,
  parameter int WORD_CHARS = 4,
  parameter int MAX_CHARS = 32,
  parameter logic [CHAR_WIDTH-1:0] NULL_CHAR = '0
) (
  input  logic                             clk_in,
  input  logic                             rst,
  input  logic [MAX_OUT_L*CHAR_WIDTH-1:0]  char_output,
  input  logic                             valid_output,
  output logic                             seg_ready,
  input  logic                             final_image,
  input  logic                             clear_buff,
  output logic [WORD_CHARS*CHAR_WIDTH-1:0] data_to_filo,
  output logic                             push_filo,
  input  logic                             filo_ready,
  output logic [7:0]                       result_lc,
  output logic                             ocr_rx_done,
  output logic                             overflow,
  output logic                             seg_dropped,
  output logic [2:0]                       dbg_state
);

  localparam int SEG_W  = MAX_OUT_L * CHAR_WIDTH;
  localparam int ACC_W  = WORD_CHARS * CHAR_WIDTH;
  localparam int IDX_W  = $clog2(MAX_OUT_L + 1);
  localparam int FILL_W = $clog2(WORD_CHARS + 1);
  localparam int TOT_W  = $clog2(MAX_CHARS + 1);

  localparam logic [CHAR_WIDTH-1:0] CH_DIG_LO = CHAR_WIDTH'(8'h30);
  localparam logic [CHAR_WIDTH-1:0] CH_DIG_HI = CHAR_WIDTH'(8'h39);
`ifdef OCR_RX_ALPHA_EN
  localparam logic [CHAR_WIDTH-1:0] CH_UC_LO  = CHAR_WIDTH'(8'h41);
  localparam logic [CHAR_WIDTH-1:0] CH_UC_HI  = CHAR_WIDTH'(8'h5A);
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_PUSH  = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [TOT_W-1:0]  total_q, total_d;
  logic              from_flush_q, from_flush_d;
  logic              seg_ready_q, seg_ready_d;
  logic              push_filo_q, push_filo_d;
  logic [ACC_W-1:0]  data_q, data_d;
  logic [7:0]        result_lc_q, result_lc_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;
  logic              seg_dropped_q, seg_dropped_d;

  logic [CHAR_WIDTH-1:0] cur_ch;
  logic                  cur_accept;
  logic [ACC_W-1:0]      flush_word;

  // Character at the current scan index; NULL once the index runs off the end.
  always_comb begin
    cur_ch = NULL_CHAR;
    for (int i = 0; i < MAX_OUT_L; i++) begin
      if (idx_q == IDX_W'(i)) cur_ch = seg_q[i*CHAR_WIDTH +: CHAR_WIDTH];
    end
  end

  always_comb begin
    cur_accept = (cur_ch >= CH_DIG_LO) && (cur_ch <= CH_DIG_HI);
`ifdef OCR_RX_ALPHA_EN
    cur_accept = cur_accept || ((cur_ch >= CH_UC_LO) && (cur_ch <= CH_UC_HI));
`endif
  end

  // The accumulator is already right-aligned; unoccupied upper slots become
  // NULL_CHAR so the result is correct even for a non-zero NULL_CHAR.
  always_comb begin
    flush_word = '0;
    for (int s = 0; s < WORD_CHARS; s++) begin
      if (s < int'(fill_q)) flush_word[s*CHAR_WIDTH +: CHAR_WIDTH] = acc_q[s*CHAR_WIDTH +: CHAR_WIDTH];
      else                  flush_word[s*CHAR_WIDTH +: CHAR_WIDTH] = NULL_CHAR;
    end
  end

  always_comb begin
    state_d      = state_q;
    seg_d        = seg_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    fill_d       = fill_q;
    total_d      = total_q;
    from_flush_d = from_flush_q;
    data_d       = data_q;
    result_lc_d  = result_lc_q;
    overflow_d   = overflow_q;

    case (state_q)
      S_IDLE: begin
        // A segment wins over final_image; final_image is seen again on return.
        if (valid_output) begin
          seg_d   = char_output;
          idx_d   = '0;
          state_d = S_SCAN;
        end else if (final_image) begin
          state_d = S_FLUSH;
        end
      end
      S_SCAN: begin
        if ((idx_q == IDX_W'(MAX_OUT_L)) || (cur_ch == NULL_CHAR)) begin
          state_d = S_IDLE;
        end else begin
          if (cur_accept) begin
            if (total_q < TOT_W'(MAX_CHARS)) begin
              acc_d   = (acc_q << CHAR_WIDTH) | ACC_W'(cur_ch);
              fill_d  = fill_q + FILL_W'(1);
              total_d = total_q + TOT_W'(1);
              if (result_lc_q != 8'hFF) result_lc_d = result_lc_q + 8'd1;
            end else begin
              overflow_d = 1'b1;
            end
          end
          // Index advances now so that scanning resumes at the next character
          // after a push.
          idx_d = idx_q + IDX_W'(1);
          if (fill_d == FILL_W'(WORD_CHARS)) begin
            data_d       = acc_d;
            from_flush_d = 1'b0;
            state_d      = S_PUSH;
          end
        end
      end
      S_PUSH: begin
        if (filo_ready) begin
          fill_d  = '0;
          acc_d   = '0;
          state_d = from_flush_q ? S_DONE : S_SCAN;
        end
      end
      S_FLUSH: begin
        if (fill_q != '0) begin
          data_d       = flush_word;
          from_flush_d = 1'b1;
          state_d      = S_PUSH;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!final_image) begin
          total_d      = '0;
          result_lc_d  = '0;
          overflow_d   = 1'b0;
          from_flush_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_comb begin
    seg_ready_d   = (state_d == S_IDLE);
    push_filo_d   = (state_d == S_PUSH);
    done_d        = (state_d == S_DONE);
    seg_dropped_d = valid_output && !seg_ready_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst || clear_buff) begin
      state_q       <= S_IDLE;
      seg_q         <= '0;
      idx_q         <= '0;
      acc_q         <= '0;
      fill_q        <= '0;
      total_q       <= '0;
      from_flush_q  <= 1'b0;
      seg_ready_q   <= 1'b1;
      push_filo_q   <= 1'b0;
      data_q        <= '0;
      result_lc_q   <= '0;
      done_q        <= 1'b0;
      overflow_q    <= 1'b0;
      seg_dropped_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      seg_q         <= seg_d;
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      fill_q        <= fill_d;
      total_q       <= total_d;
      from_flush_q  <= from_flush_d;
      seg_ready_q   <= seg_ready_d;
      push_filo_q   <= push_filo_d;
      data_q        <= data_d;
      result_lc_q   <= result_lc_d;
      done_q        <= done_d;
      overflow_q    <= overflow_d;
      seg_dropped_q <= seg_dropped_d;
    end
  end

  assign seg_ready    = seg_ready_q;
  assign push_filo    = push_filo_q;
  assign data_to_filo = data_q;
  assign result_lc    = result_lc_q;
  assign ocr_rx_done  = done_q;
  assign overflow     = overflow_q;
  assign seg_dropped  = seg_dropped_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ocr_rx_packer.sv
// ---------------------------------------------------------------------------
// tb_ocr_rx_packer
//
// Directed scenarios plus randomized images for ocr_rx_packer. Expected words
// come from a reference model that keeps the list of accepted characters per
// image and cuts it into words; observed transfers are captured on the
// falling edge into obs_q.
// ---------------------------------------------------------------------------
module tb_ocr_rx_packer;

  localparam int MAX_OUT_L  = 8;
  localparam int CHAR_WIDTH = 8;
  localparam int WORD_CHARS = 4;
  localparam int MAX_CHARS  = 32;
  localparam int SEG_W      = MAX_OUT_L * CHAR_WIDTH;
  localparam int WORD_W     = WORD_CHARS * CHAR_WIDTH;

  // ---------------- clock / reset / DUT ----------------
  logic              clk_in = 1'b0;
  logic              rst = 1'b1;
  logic [SEG_W-1:0]  char_output = '0;
  logic              valid_output = 1'b0;
  logic              seg_ready;
  logic              final_image = 1'b0;
  logic              clear_buff = 1'b0;
  logic [WORD_W-1:0] data_to_filo;
  logic              push_filo;
  logic              filo_ready = 1'b1;
  logic [7:0]        result_lc;
  logic              ocr_rx_done;
  logic              overflow;
  logic              seg_dropped;
  logic [2:0]        dbg_state;

  always #5 clk_in = ~clk_in;

  ocr_rx_packer #(
    .MAX_OUT_L(MAX_OUT_L), .CHAR_WIDTH(CHAR_WIDTH), .WORD_CHARS(WORD_CHARS),
    .MAX_CHARS(MAX_CHARS), .NULL_CHAR(8'h00)
  ) dut (
    .clk_in(clk_in), .rst(rst), .char_output(char_output), .valid_output(valid_output),
    .seg_ready(seg_ready), .final_image(final_image), .clear_buff(clear_buff),
    .data_to_filo(data_to_filo), .push_filo(push_filo), .filo_ready(filo_ready),
    .result_lc(result_lc), .ocr_rx_done(ocr_rx_done), .overflow(overflow),
    .seg_dropped(seg_dropped), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard ----------------
  logic [WORD_W-1:0] exp_q[$];
  logic [WORD_W-1:0] obs_q[$];

  always @(negedge clk_in) begin
    if (!rst && !clear_buff && push_filo && filo_ready) obs_q.push_back(data_to_filo);
  end

  bit rand_ready_en = 1'b0;
  always @(posedge clk_in) begin
    if (rand_ready_en) begin
      #2;
      if (rand_ready_en) filo_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] m_pend[$];
  int         m_total = 0;
  int         m_lc = 0;
  logic       m_ovf = 1'b0;

  function automatic bit is_acc(input logic [7:0] c);
    bit a;
    a = (c >= 8'h30) && (c <= 8'h39);
`ifdef OCR_RX_ALPHA_EN
    a = a || ((c >= 8'h41) && (c <= 8'h5A));
`endif
    return a;
  endfunction

  // First accepted character sits in the most significant occupied slot.
  function automatic logic [WORD_W-1:0] pack_word();
    logic [WORD_W-1:0] w;
    int k;
    w = '0;
    k = m_pend.size();
    for (int j = 0; j < k; j++) w[8*(k-1-j) +: 8] = m_pend[j];
    return w;
  endfunction

  task automatic model_segment(input logic [SEG_W-1:0] s);
    logic [7:0] c;
    for (int i = 0; i < MAX_OUT_L; i++) begin
      c = s[8*i +: 8];
      if (c == 8'h00) break;
      if (is_acc(c)) begin
        if (m_total < MAX_CHARS) begin
          m_pend.push_back(c);
          m_total++;
          if (m_lc < 255) m_lc++;
          if (m_pend.size() == WORD_CHARS) begin
            exp_q.push_back(pack_word());
            m_pend.delete();
          end
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic model_final();
    if (m_pend.size() > 0) begin
      exp_q.push_back(pack_word());
      m_pend.delete();
    end
  endtask

  task automatic model_clear();
    m_pend.delete();
    m_total = 0;
    m_lc = 0;
    m_ovf = 1'b0;
  endtask

  function automatic logic [SEG_W-1:0] seg_from_str(input string s);
    logic [SEG_W-1:0] r;
    r = '0;
    for (int i = 0; i < s.len() && i < MAX_OUT_L; i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  function automatic logic [7:0] rand_char();
    int k;
    k = $urandom_range(0, 11);
    if (k < 6)  return 8'h30 + 8'($urandom_range(0, 9));
    if (k < 8)  return 8'h41 + 8'($urandom_range(0, 25));
    if (k < 10) return 8'($urandom_range(33, 47));
    if (k == 10) return 8'h61 + 8'($urandom_range(0, 25));
    return 8'h00;
  endfunction

  // ---------------- driver tasks (all start/end at posedge + 1) ----------------
  task automatic wait_seg_ready(input string tag);
    int n;
    n = 0;
    while (seg_ready !== 1'b1 && n < 500) begin @(posedge clk_in); #1; n++; end
    if (seg_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s_timeout: seg_ready=%b required 1", tag, seg_ready);
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (ocr_rx_done !== 1'b1 && n < 500) begin @(posedge clk_in); #1; n++; end
    if (ocr_rx_done !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s_timeout: ocr_rx_done=%b required 1", tag, ocr_rx_done);
    end
  endtask

  task automatic send_seg(input logic [SEG_W-1:0] s);
    wait_seg_ready("send");
    char_output = s;
    valid_output = 1'b1;
    @(posedge clk_in); #1;
    valid_output = 1'b0;
    model_segment(s);
  endtask

  task automatic start_final();
    final_image = 1'b1;
    model_final();
    wait_done("final");
  endtask

  task automatic release_final();
    final_image = 1'b0;
    wait_seg_ready("release");
    model_clear();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    if (seg_ready !== 1'b1) begin errors++; $display("FAIL reset_seg_ready: got %b need 1", seg_ready); end
    checks++;
    if (push_filo !== 1'b0) begin errors++; $display("FAIL reset_push: got %b need 0", push_filo); end
    checks++;
    if (data_to_filo !== '0) begin errors++; $display("FAIL reset_data: got %h need 0", data_to_filo); end
    checks++;
    if (result_lc !== 8'd0) begin errors++; $display("FAIL reset_lc: got %0d need 0", result_lc); end
    checks++;
    if (ocr_rx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b need 0", ocr_rx_done); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b need 0", overflow); end
    checks++;
    if (seg_dropped !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b need 0", seg_dropped); end
    checks++;
    if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d need 0", dbg_state); end
    checks++;
    rst = 1'b0;
    @(posedge clk_in); #1;
    model_clear();
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_pack_flush();
    int n;
    obs_q.delete(); exp_q.delete();
    send_seg(seg_from_str("123"));
    n = 0;
    while (seg_ready !== 1'b1 && n < 50) begin @(posedge clk_in); #1; n++; end
    if (n != 4) begin errors++; $display("FAIL pf_latency: got %0d cycles need 4", n); end
    checks++;
    send_seg(seg_from_str("45"));
    wait_seg_ready("pf_idle");
    start_final();
    if (obs_q.size() != 2) begin errors++; $display("FAIL pf_count: got %0d words need 2", obs_q.size()); end
    else begin
      if (obs_q[0] !== 32'h31323334) begin errors++; $display("FAIL pf_word0: got %h need 31323334", obs_q[0]); end
      checks++;
      if (obs_q[1] !== 32'h00000035) begin errors++; $display("FAIL pf_word1: got %h need 00000035", obs_q[1]); end
    end
    checks++;
    if (result_lc !== 8'd5) begin errors++; $display("FAIL pf_lc: got %0d need 5", result_lc); end
    checks++;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk_in); #1;
      if (ocr_rx_done !== 1'b1) begin errors++; $display("FAIL pf_done_hold: got %b need 1", ocr_rx_done); end
      checks++;
    end
    release_final();
    if (ocr_rx_done !== 1'b0) begin errors++; $display("FAIL pf_done_fall: got %b need 0", ocr_rx_done); end
    checks++;
    if (result_lc !== 8'd0) begin errors++; $display("FAIL pf_lc_clear: got %0d need 0", result_lc); end
    checks++;
  endtask

  task automatic test_filter();
    logic [7:0]        lc_exp;
    logic [WORD_W-1:0] w_exp;
`ifdef OCR_RX_ALPHA_EN
    lc_exp = 8'd3; w_exp = 32'h00314132;
`else
    lc_exp = 8'd2; w_exp = 32'h00003132;
`endif
    obs_q.delete(); exp_q.delete();
    send_seg(seg_from_str("1A-2"));
    wait_seg_ready("flt_idle");
    if (result_lc !== lc_exp) begin errors++; $display("FAIL flt_lc: got %0d need %0d", result_lc, lc_exp); end
    checks++;
    start_final();
    if (obs_q.size() != 1) begin errors++; $display("FAIL flt_count: got %0d words need 1", obs_q.size()); end
    else if (obs_q[0] !== w_exp) begin errors++; $display("FAIL flt_word: got %h need %h", obs_q[0], w_exp); end
    checks++;
    release_final();
  endtask

  task automatic test_backpressure();
    obs_q.delete(); exp_q.delete();
    filo_ready = 1'b0;
    send_seg(seg_from_str("1234"));
    for (int n = 0; n < 20 && push_filo !== 1'b1; n++) begin @(posedge clk_in); #1; end
    for (int c = 0; c < 5; c++) begin
      if (push_filo !== 1'b1) begin errors++; $display("FAIL bp_push_hold: got %b need 1", push_filo); end
      checks++;
      if (data_to_filo !== 32'h31323334) begin errors++; $display("FAIL bp_data_hold: got %h need 31323334", data_to_filo); end
      checks++;
      if (seg_ready !== 1'b0) begin errors++; $display("FAIL bp_seg_ready: got %b need 0", seg_ready); end
      checks++;
      if (c == 1) begin
        if (seg_dropped !== 1'b1) begin errors++; $display("FAIL bp_dropped: got %b need 1", seg_dropped); end
        checks++;
      end
      if (c == 2) begin
        if (seg_dropped !== 1'b0) begin errors++; $display("FAIL bp_dropped_pulse: got %b need 0", seg_dropped); end
        checks++;
        if (dbg_state !== 3'd2) begin errors++; $display("FAIL bp_state: got %0d need 2", dbg_state); end
        checks++;
      end
      if (c == 0) begin char_output = seg_from_str("9"); valid_output = 1'b1; end
      else valid_output = 1'b0;
      @(posedge clk_in); #1;
    end
    filo_ready = 1'b1;
    wait_seg_ready("bp_idle");
    start_final();
    if (obs_q.size() != 1) begin errors++; $display("FAIL bp_transfers: got %0d need 1", obs_q.size()); end
    else if (obs_q[0] !== 32'h31323334) begin errors++; $display("FAIL bp_word: got %h need 31323334", obs_q[0]); end
    checks++;
    release_final();
  endtask

  task automatic test_capacity();
    obs_q.delete(); exp_q.delete();
    for (int s = 0; s < 4; s++) send_seg(seg_from_str("12345678"));
    wait_seg_ready("cap_idle");
    if (overflow !== 1'b0) begin errors++; $display("FAIL cap_ovf_early: got %b need 0", overflow); end
    checks++;
    send_seg(seg_from_str("123456"));
    wait_seg_ready("cap_idle2");
    if (overflow !== 1'b1) begin errors++; $display("FAIL cap_ovf: got %b need 1", overflow); end
    checks++;
    if (result_lc !== 8'd32) begin errors++; $display("FAIL cap_lc: got %0d need 32", result_lc); end
    checks++;
    start_final();
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL cap_count: got %0d need %0d", obs_q.size(), exp_q.size()); end
    checks++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL cap_word%0d: got %h need %h", i, obs_q[i], exp_q[i]); end
      checks++;
    end
    release_final();
  endtask

  task automatic test_clear();
    obs_q.delete(); exp_q.delete();
    send_seg(seg_from_str("123"));
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    if (dbg_state !== 3'd1) begin errors++; $display("FAIL clr_pre_state: got %0d need 1", dbg_state); end
    checks++;
    if (result_lc !== 8'd2) begin errors++; $display("FAIL clr_pre_lc: got %0d need 2", result_lc); end
    checks++;
    clear_buff = 1'b1;
    @(posedge clk_in); #1;
    clear_buff = 1'b0;
    model_clear();
    if (dbg_state !== 3'd0) begin errors++; $display("FAIL clr_state: got %0d need 0", dbg_state); end
    checks++;
    if (push_filo !== 1'b0) begin errors++; $display("FAIL clr_push: got %b need 0", push_filo); end
    checks++;
    if (result_lc !== 8'd0) begin errors++; $display("FAIL clr_lc: got %0d need 0", result_lc); end
    checks++;
    if (seg_ready !== 1'b1) begin errors++; $display("FAIL clr_seg_ready: got %b need 1", seg_ready); end
    checks++;
    send_seg(seg_from_str("9"));
    wait_seg_ready("clr_idle");
    start_final();
    if (obs_q.size() != 1) begin errors++; $display("FAIL clr_count: got %0d need 1", obs_q.size()); end
    else if (obs_q[0] !== 32'h00000039) begin errors++; $display("FAIL clr_word: got %h need 00000039", obs_q[0]); end
    checks++;
    release_final();
  endtask

  task automatic test_simultaneous();
    obs_q.delete(); exp_q.delete();
    wait_seg_ready("sim_idle");
    char_output = seg_from_str("7");
    valid_output = 1'b1;
    final_image = 1'b1;
    @(posedge clk_in); #1;
    valid_output = 1'b0;
    model_segment(seg_from_str("7"));
    model_final();
    wait_done("sim_done");
    if (obs_q.size() != 1) begin errors++; $display("FAIL sim_count: got %0d need 1", obs_q.size()); end
    else if (obs_q[0] !== 32'h00000037) begin errors++; $display("FAIL sim_word: got %h need 00000037", obs_q[0]); end
    checks++;
    if (result_lc !== 8'd1) begin errors++; $display("FAIL sim_lc: got %0d need 1", result_lc); end
    checks++;
    release_final();
  endtask

  task automatic test_random();
    logic [SEG_W-1:0] s;
    int nseg;
    rand_ready_en = 1'b1;
    for (int img = 0; img < 6; img++) begin
      obs_q.delete(); exp_q.delete();
      nseg = $urandom_range(1, 7);
      for (int k = 0; k < nseg; k++) begin
        for (int i = 0; i < MAX_OUT_L; i++) s[8*i +: 8] = rand_char();
        send_seg(s);
      end
      wait_seg_ready("rnd_idle");
      start_final();
      if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_count: got %0d need %0d", img, obs_q.size(), exp_q.size()); end
      checks++;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_word%0d: got %h need %h", img, i, obs_q[i], exp_q[i]); end
        checks++;
      end
      if (result_lc !== 8'(m_lc)) begin errors++; $display("FAIL rnd%0d_lc: got %0d need %0d", img, result_lc, m_lc); end
      checks++;
      if (overflow !== m_ovf) begin errors++; $display("FAIL rnd%0d_ovf: got %b need %b", img, overflow, m_ovf); end
      checks++;
      release_final();
    end
    rand_ready_en = 1'b0;
    @(posedge clk_in); #1;
    filo_ready = 1'b1;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_pack_flush();
    test_filter();
    test_backpressure();
    test_capacity();
    test_clear();
    test_simultaneous();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
